// File: rtl/alu_share_arbiter_if.sv
// Bundles the two requester channels, the shared-ALU channel and the tagged
// response channel of alu_share_arbiter.
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 5
);
  logic              r0_valid;
  logic              r0_ready;
  logic [DATA_W-1:0] r0_a;
  logic [DATA_W-1:0] r0_b;
  logic [CTRL_W-1:0] r0_ctrl;
  logic              r1_valid;
  logic              r1_ready;
  logic [DATA_W-1:0] r1_a;
  logic [DATA_W-1:0] r1_b;
  logic [CTRL_W-1:0] r1_ctrl;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [DATA_W-1:0] resp_result;
  logic              resp_zero;

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_ctrl,
    input  r1_valid, r1_a, r1_b, r1_ctrl,
    input  alu_result, alu_zero, resp_ready,
    output r0_ready, r1_ready, alu_a, alu_b, alu_ctrl,
    output resp_valid, resp_id, resp_result, resp_zero
  );

  modport master (
    output r0_valid, r0_a, r0_b, r0_ctrl,
    output r1_valid, r1_a, r1_b, r1_ctrl,
    output alu_result, alu_zero, resp_ready,
    input  r0_ready, r1_ready, alu_a, alu_b, alu_ctrl,
    input  resp_valid, resp_id, resp_result, resp_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters (IDLE->EXEC->RESP).
// Optional feature: define ALU_ARB_RR_EN for round-robin tie breaking.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic              gnt_valid_s;
  logic              gnt_id_s;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic              id_r;
  logic              resp_valid_r;
  logic [DATA_W-1:0] resp_result_r;
  logic              resp_zero_r;
`ifdef ALU_ARB_RR_EN
  logic              last_grant_r;
`endif

  // Arbitration: only in IDLE and never while reset is asserted
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_id_s    = 1'b0;
    if (!rst && (state_r == IDLE)) begin
      if (bus.r0_valid && bus.r1_valid) begin
        gnt_valid_s = 1'b1;
`ifdef ALU_ARB_RR_EN
        gnt_id_s    = ~last_grant_r;
`else
        gnt_id_s    = 1'b0;
`endif
      end else if (bus.r0_valid) begin
        gnt_valid_s = 1'b1;
        gnt_id_s    = 1'b0;
      end else if (bus.r1_valid) begin
        gnt_valid_s = 1'b1;
        gnt_id_s    = 1'b1;
      end else begin
        gnt_valid_s = 1'b0;
        gnt_id_s    = 1'b0;
      end
    end else begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = 1'b0;
    end
  end

  assign bus.r0_ready = gnt_valid_s & ~gnt_id_s;
  assign bus.r1_ready = gnt_valid_s &  gnt_id_s;

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_valid_s) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: state_next_s = RESP;
      RESP: begin
        if (bus.resp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture, result capture and response hold
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r           <= {DATA_W{1'b0}};
      b_r           <= {DATA_W{1'b0}};
      ctrl_r        <= {CTRL_W{1'b0}};
      id_r          <= 1'b0;
      resp_valid_r  <= 1'b0;
      resp_result_r <= {DATA_W{1'b0}};
      resp_zero_r   <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_grant_r  <= 1'b1;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_valid_s) begin
            a_r    <= gnt_id_s ? bus.r1_a    : bus.r0_a;
            b_r    <= gnt_id_s ? bus.r1_b    : bus.r0_b;
            ctrl_r <= gnt_id_s ? bus.r1_ctrl : bus.r0_ctrl;
            id_r   <= gnt_id_s;
`ifdef ALU_ARB_RR_EN
            last_grant_r <= gnt_id_s;
`endif
          end
        end
        EXEC: begin
          resp_result_r <= bus.alu_result;
          resp_zero_r   <= bus.alu_zero;
          resp_valid_r  <= 1'b1;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_r <= 1'b0;
          end
        end
        default: resp_valid_r <= 1'b0;
      endcase
    end
  end

  // The ALU sees only registered operands, so it holds steady outside EXEC
  assign bus.alu_a       = a_r;
  assign bus.alu_b       = b_r;
  assign bus.alu_ctrl    = ctrl_r;
  assign bus.resp_valid  = resp_valid_r;
  assign bus.resp_id     = id_r;
  assign bus.resp_result = resp_result_r;
  assign bus.resp_zero   = resp_zero_r;

endmodule
